// File: rtl/window_generator.sv
// ---------------------------------------------------------------------------
// window_generator
//
// Turns a raster-order 8-bit pixel stream into a stream of 3x3 neighbourhood
// windows, one window per image pixel, in raster order of the window centre.
// Rows r-1 and r sit in two line buffers. The incoming pixel supplies row r+1.
// Three columns of the neighbourhood are kept in a shifting 3x3 register array.
//
// Out-of-image taps are zero by default. When the macro
// WINDOW_BORDER_REPLICATE_EN is defined they take the nearest in-image pixel
// instead (edge replication).
//
// Parameters
//   IMG_WIDTH       pixels per line (4..2048)
//   IMG_HEIGHT      lines per frame (3..2048)
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   input_valid     pixel offered this cycle
//   input_pixel     raster-order pixel
//   input_ready     pixel accepted when input_valid && input_ready at clk edge
//   window_valid    window on window_pixel_* is valid for this cycle
//   window_sof      window centred at (0,0)
//   window_eof      window centred at (IMG_HEIGHT-1, IMG_WIDTH-1)
//   window_pixel_1..9  3x3 window, row-major; window_pixel_5 is the centre
// ---------------------------------------------------------------------------
module window_generator #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       input_valid,
  input  logic [7:0] input_pixel,
  output logic       input_ready,
  output logic       window_valid,
  output logic       window_sof,
  output logic       window_eof,
  output logic [7:0] window_pixel_1,
  output logic [7:0] window_pixel_2,
  output logic [7:0] window_pixel_3,
  output logic [7:0] window_pixel_4,
  output logic [7:0] window_pixel_5,
  output logic [7:0] window_pixel_6,
  output logic [7:0] window_pixel_7,
  output logic [7:0] window_pixel_8,
  output logic [7:0] window_pixel_9
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // Indexed as [row][col]; row 0 is the top row of the window.
  typedef logic [2:0][2:0][7:0] win_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    EOL   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] col_r, col_s;
  logic [RW-1:0] row_r, row_s;
  logic          eol_top_r, eol_top_s;    // pending EOL window is on row 0
  logic          eol_last_r, eol_last_s;  // pending EOL ends the last input row
  logic          ready_r;
  logic          valid_r, sof_r, eof_r;
  win_t          win_r, win_next_s, win_out_r;

  // Line buffer A holds row r-1 and line buffer B holds row r, relative to the
  // row currently arriving (r+1). Contents are never reset. Stale entries are
  // only read at positions that the border masks replace.
  logic [7:0]    lb_a_r [IMG_WIDTH];
  logic [7:0]    lb_b_r [IMG_WIDTH];

  logic          accept_s, shift_s, lb_we_s, emit_s, sof_s, eof_s;
  logic          top_s, bot_s, left_s, right_s;
  logic [CW-1:0] rd_addr_s;
  logic [7:0]    bot_pix_s;

  // Replace out-of-image taps, either by zero or by the nearest in-image tap.
  // Rows are fixed first, so corner taps pick up the replicated row value.
  function automatic win_t apply_border(input win_t w, input logic top,
                                        input logic bot, input logic left,
                                        input logic right);
    win_t v;
    v = w;
`ifdef WINDOW_BORDER_REPLICATE_EN
    if (top) v[0] = w[1];
    if (bot) v[2] = w[1];
    for (int i = 0; i < 3; i++) begin
      if (left)  v[i][0] = v[i][1];
      if (right) v[i][2] = v[i][1];
    end
`else
    if (top) v[0] = '0;
    if (bot) v[2] = '0;
    for (int i = 0; i < 3; i++) begin
      if (left)  v[i][0] = 8'd0;
      if (right) v[i][2] = 8'd0;
    end
`endif
    return v;
  endfunction

  assign accept_s = input_valid & ready_r;

  // FSM state, counters and EOL context flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FILL;
      col_r      <= '0;
      row_r      <= '0;
      eol_top_r  <= 1'b0;
      eol_last_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      col_r      <= col_s;
      row_r      <= row_s;
      eol_top_r  <= eol_top_s;
      eol_last_r <= eol_last_s;
    end
  end

  // Next-state, counter update and per-cycle datapath control.
  always_comb begin
    state_s    = state_r;
    col_s      = col_r;
    row_s      = row_r;
    eol_top_s  = eol_top_r;
    eol_last_s = eol_last_r;
    shift_s    = 1'b0;
    lb_we_s    = 1'b0;
    emit_s     = 1'b0;
    sof_s      = 1'b0;
    eof_s      = 1'b0;
    top_s      = 1'b0;
    bot_s      = 1'b0;
    left_s     = 1'b0;
    right_s    = 1'b0;
    rd_addr_s  = col_r;
    bot_pix_s  = input_pixel;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          shift_s = 1'b1;
          lb_we_s = 1'b1;
          if (col_r == COL_LAST) begin
            col_s   = '0;
            row_s   = RW'(1);
            state_s = RUN;
          end else begin
            col_s = col_r + CW'(1);
          end
        end else begin
          state_s = FILL;
        end
      end
      RUN: begin
        if (accept_s) begin
          // Accepting (r+1,c) completes the window centred at (r,c-1).
          shift_s = 1'b1;
          lb_we_s = 1'b1;
          emit_s  = (col_r != '0);
          left_s  = (col_r == CW'(1));
          top_s   = (row_r == RW'(1));
          sof_s   = (row_r == RW'(1)) && (col_r == CW'(1));
          if (col_r == COL_LAST) begin
            col_s      = '0;
            eol_top_s  = (row_r == RW'(1));
            eol_last_s = (row_r == ROW_LAST);
            // The row counter saturates on the last row; FLUSH reuses it.
            row_s      = (row_r == ROW_LAST) ? row_r : row_r + RW'(1);
            state_s    = EOL;
          end else begin
            col_s = col_r + CW'(1);
          end
        end else begin
          state_s = RUN;
        end
      end
      EOL: begin
        // The right column is masked. The loaded column is column 0 of the
        // two buffered rows, which is exactly what the first FLUSH window
        // needs when this is the last row.
        shift_s   = 1'b1;
        emit_s    = 1'b1;
        right_s   = 1'b1;
        top_s     = eol_top_r;
        rd_addr_s = '0;
        bot_pix_s = 8'd0;
        state_s   = eol_last_r ? FLUSH : RUN;
      end
      FLUSH: begin
        // The column counter walks the centre column of the last row.
        shift_s   = 1'b1;
        emit_s    = 1'b1;
        bot_s     = 1'b1;
        left_s    = (col_r == '0);
        right_s   = (col_r == COL_LAST);
        eof_s     = (col_r == COL_LAST);
        rd_addr_s = (col_r == COL_LAST) ? '0 : col_r + CW'(1);
        bot_pix_s = 8'd0;
        if (col_r == COL_LAST) begin
          col_s   = '0;
          row_s   = '0;
          state_s = FILL;
        end else begin
          col_s = col_r + CW'(1);
        end
      end
      default: begin
        state_s = FILL;
        col_s   = '0;
        row_s   = '0;
      end
    endcase
  end

  // Shift the tap array one column left and load the newest column on the right.
  always_comb begin
    win_next_s = win_r;
    for (int i = 0; i < 3; i++) begin
      win_next_s[i][0] = win_r[i][1];
      win_next_s[i][1] = win_r[i][2];
    end
    win_next_s[0][2] = lb_a_r[rd_addr_s];
    win_next_s[1][2] = lb_b_r[rd_addr_s];
    win_next_s[2][2] = bot_pix_s;
  end

  // Line buffers: the older row moves to A and the incoming pixel goes to B.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      lb_a_r[col_r] <= lb_b_r[col_r];
      lb_b_r[col_r] <= input_pixel;
    end
  end

  // Tap array, registered window outputs and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r     <= '0;
      win_out_r <= '0;
      valid_r   <= 1'b0;
      sof_r     <= 1'b0;
      eof_r     <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      if (shift_s) win_r <= win_next_s;
      if (emit_s)  win_out_r <= apply_border(win_next_s, top_s, bot_s, left_s, right_s);
      valid_r <= emit_s;
      sof_r   <= sof_s;
      eof_r   <= eof_s;
      ready_r <= (state_s == FILL) || (state_s == RUN);
    end
  end

  assign input_ready    = ready_r;
  assign window_valid   = valid_r;
  assign window_sof     = sof_r;
  assign window_eof     = eof_r;
  assign window_pixel_1 = win_out_r[0][0];
  assign window_pixel_2 = win_out_r[0][1];
  assign window_pixel_3 = win_out_r[0][2];
  assign window_pixel_4 = win_out_r[1][0];
  assign window_pixel_5 = win_out_r[1][1];
  assign window_pixel_6 = win_out_r[1][2];
  assign window_pixel_7 = win_out_r[2][0];
  assign window_pixel_8 = win_out_r[2][1];
  assign window_pixel_9 = win_out_r[2][2];

endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 Parameter IMG_WIDTH, default 512, pixels per line (legal range 4..2048).
REQ-002 Parameter IMG_HEIGHT, default 512, lines per frame (legal range 3..2048).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 input_valid input 1: pixel offered this cycle; input_pixel input 8: raster-order 8-bit pixel.
REQ-005 input_ready output 1: pixel accepted when input_valid and input_ready are both high on a clk edge.
REQ-006 window_valid output 1: the 3x3 window on the output pixel ports is valid for exactly this cycle.
REQ-007 window_pixel_1..window_pixel_9 outputs 8 each: 3x3 window, row-major, top-left to bottom-right; window_pixel_5 is the centre pixel.
REQ-008 window_sof output 1: window centred at (0,0); window_eof output 1: window centred at (IMG_HEIGHT-1, IMG_WIDTH-1).

Function
REQ-009 The window centred at (r,c) SHALL carry taps (r-1,c-1),(r-1,c),(r-1,c+1),(r,c-1),(r,c),(r,c+1),(r+1,c-1),(r+1,c),(r+1,c+1) on window_pixel_1..9 respectively.
REQ-010 Storage SHALL be two IMG_WIDTH x 8 line buffers plus a 3x3 register array; column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) SHALL advance on each accepted pixel, col wrapping to 0 with row incrementing.
REQ-011 FSM states: FILL, RUN, EOL, FLUSH; the reset state is FILL.
REQ-012 FILL: input_ready=1; row 0 is accepted and no windows are emitted; accepting (0,IMG_WIDTH-1) -> RUN.
REQ-013 RUN: input_ready=1; accepting pixel (r+1,c) with c>=1 SHALL emit the window centred at (r,c-1) on the next cycle; c=0 emits nothing; accepting (r+1,IMG_WIDTH-1) -> EOL.
REQ-014 EOL: exactly one cycle, input_ready=0; emits the window centred at (r,IMG_WIDTH-1) on the next cycle; then -> RUN, or -> FLUSH if r+1 = IMG_HEIGHT-1.
REQ-015 FLUSH: input_ready=0 for IMG_WIDTH cycles; emits row IMG_HEIGHT-1 windows, columns 0..IMG_WIDTH-1, one per cycle, with no input; then -> FILL with counters cleared.
REQ-016 Output ports SHALL be registered; window_valid SHALL be high exactly IMG_WIDTH*IMG_HEIGHT cycles per frame.
REQ-017 input_valid low SHALL stall progress without losing state; windows are only emitted on acceptance, EOL, or FLUSH cycles.
REQ-018 Out-of-image taps (row -1, row IMG_HEIGHT, col -1, col IMG_WIDTH) are governed by REQ-023/REQ-024; in-image taps SHALL be exact input values.
REQ-019 Pixel ports SHALL hold their last values when window_valid=0.

Reset
REQ-020 rst_n low SHALL asynchronously force state=FILL, row=col=0, window_valid=0, window_sof=0, window_eof=0, and all window_pixel_* = 0; input_ready reads 1 during and after reset.
REQ-021 Reset mid-frame SHALL discard the partial frame; the first pixel accepted after release is (0,0).
REQ-022 Line-buffer contents need not be reset; stale data SHALL never appear on the outputs.

Configuration
REQ-023 With macro WINDOW_BORDER_REPLICATE_EN defined, each out-of-image tap SHALL take the value of the nearest in-image pixel (edge replication, corners included).
REQ-024 Without WINDOW_BORDER_REPLICATE_EN, each out-of-image tap SHALL be 8'd0; latency and handshake behaviour are unchanged.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, pixel(r,c)=16r+c, input_valid held high)
REQ-025 Full frame -> 12 window_valid pulses; window_sof on the first pulse, window_eof on the last; input_ready low for exactly 1 cycle after each of rows 1 and 2, then 4 FLUSH cycles.
REQ-026 Window (1,1) -> window_pixel_1..9 = 0,1,2,16,17,18,32,33,34, emitted the cycle after pixel (2,2) is accepted.
REQ-027 Window (0,0) with WINDOW_BORDER_REPLICATE_EN -> 0,0,1,0,0,1,16,16,17; without the macro -> 0,0,0,0,0,1,0,16,17.
REQ-028 Window (2,3) with the macro -> 18,19,19,34,35,35,34,35,35; without the macro -> 18,19,0,34,35,0,0,0,0.
REQ-029 input_valid toggling 1/0 each cycle -> window sequence and values identical to REQ-025, spread over time.
REQ-030 rst_n pulsed low after pixel (1,2), then a full frame -> outputs zeroed immediately; the full 12-window frame then matches REQ-025/026.
